// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared processor definitions for the skid-buffered pipeline register
package pipe_skid_reg_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } skid_state_e;
endpackage

// File: rtl/pipe_skid_reg_nbit_reg.sv
// nbit_reg: WIDTH-bit register with load enable and synchronous active-high reset
module nbit_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid pipeline register with flush; every output comes straight from a flop
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    skid_state_e      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [1:0]       occ_q;
    logic             in_xfer, out_xfer, main_ld, skid_ld;
    logic [WIDTH-1:0] main_q, skid_q, main_d;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;
    assign main_d   = (state_q == SKID) ? skid_q : in_data;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        case (state_q)
            EMPTY: begin
                state_d = in_xfer ? FULL : EMPTY;
                main_ld = in_xfer;
            end
            FULL: begin
                state_d = in_xfer ? (out_xfer ? FULL : SKID) : (out_xfer ? EMPTY : FULL);
                main_ld = in_xfer & out_xfer;
                skid_ld = in_xfer & ~out_xfer;
            end
            SKID: begin
                state_d = out_xfer ? FULL : SKID;
                main_ld = out_xfer;
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins over every handshake move, including a same-cycle input transfer.
        if (flush) begin
            state_d = EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d != SKID;
            out_valid_q <= state_d != EMPTY;
            occ_q       <= (state_d == SKID) ? 2'd2 : (state_d == FULL) ? 2'd1 : 2'd0;
        end
    end

    nbit_reg #(.WIDTH(WIDTH)) u_main (
        .clk(clk), .rst(rst), .ld(main_ld), .d(main_d), .q(main_q)
    );

    nbit_reg #(.WIDTH(WIDTH)) u_skid (
        .clk(clk), .rst(rst), .ld(skid_ld), .d(in_data), .q(skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random stimulus checked by a queue scoreboard
module tb_pipe_skid_reg;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic [31:0] exp_q[$];
    logic        after_rst = 1'b0;
    logic        done = 1'b0;
    int          n_cmp = 0, n_fail = 0;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Scoreboard: the held-entry queue is the model; flags and data are derived from its size and head.
    initial begin
        int sz;
        logic do_in, do_out;
        while (!done) begin
            @(posedge clk);
            sz     = exp_q.size();
            do_in  = in_valid && sz < 2;
            do_out = out_ready && sz > 0;
            if (rst) begin
                exp_q.delete();
                after_rst = 1'b1;
            end else if (flush) begin
                exp_q.delete();
            end else begin
                if (do_out) void'(exp_q.pop_front());
                if (do_in) begin
                    exp_q.push_back(in_data);
                    after_rst = 1'b0;
                end
            end
            @(negedge clk);
            sz = exp_q.size();
            chk("in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
            chk("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
            chk("occupancy", {30'd0, occupancy}, sz);
            if (sz > 0) chk("out_data", out_data, exp_q[0]);
            else if (after_rst) chk("out_data_reset", out_data, 32'd0);
        end
    end

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h11, 1);
        drive(0, 0, 1, 32'h22, 1);
        drive(0, 0, 1, 32'h33, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hA, 0);
        drive(0, 0, 1, 32'hB, 0);
        drive(0, 0, 1, 32'hEE, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hA, 0);
        drive(0, 0, 1, 32'hB, 0);
        drive(0, 1, 1, 32'hC, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'h55, 0);
        drive(1, 1, 1, 32'h66, 0);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(499) == 0, $urandom_range(49) == 0, $urandom_range(1) == 1,
                  $urandom, $urandom_range(3) != 0);
        drive(0, 0, 0, 0, 1);
        done = 1'b1;
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
